// File: rtl/s4ga_seq.sv
// Configuration sequencer for an s4ga LUT core: loads a segment image, then streams it frame by frame.
// Optional frame counter output enabled by defining S4GA_SEQ_FRAME_CNT_EN.
module s4ga_seq #(
  parameter int N    = 16,
  parameter int K    = 4,
  parameter int SI_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_wrValid,
  output logic            o_wrReady,
  input  logic [SI_W-1:0] i_wrData,
  input  logic            i_start,
  input  logic            i_stop,
  output logic [SI_W-1:0] o_coreSi,
  output logic            o_coreRst,
  output logic            o_coreClkEn,
  output logic            o_busy,
  output logic            o_cfgValid,
  output logic            o_frameDone
`ifdef S4GA_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]     o_frameCnt
`endif
);

  localparam int IDX_BITS  = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_SEGS  = (IDX_BITS + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((2 ** K) + SI_W - 1) / SI_W;
  localparam int LUT_SEGS  = K * IDX_SEGS + MASK_SEGS;
  localparam int DEPTH     = N * LUT_SEGS;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = $clog2(N + 2);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CRST,
    ST_RUN
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_stopPend;
  logic            r_cfgValid;
  logic [SI_W-1:0] r_mem [DEPTH];

  logic            w_accept;
  logic            w_startAccept;
  logic            w_lastPtr;
  logic            w_frameDone;
  logic [SI_W-1:0] w_memRd;

  assign w_memRd = r_mem[r_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_accept      = 1'b0;
    w_startAccept = 1'b0;
    w_lastPtr     = (r_ptr == LAST_ADDR);
    w_frameDone   = 1'b0;
    o_wrReady     = 1'b0;
    o_coreSi      = '0;
    o_coreRst     = 1'b0;
    o_coreClkEn   = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_load) begin
          w_nextState = ST_LOAD;
        end else if (i_start && r_cfgValid) begin
          w_startAccept = 1'b1;
          w_nextState   = ST_CRST;
        end
      end
      ST_LOAD: begin
        o_wrReady = 1'b1;
        w_accept  = i_wrValid;
        if (i_wrValid && (r_addr == LAST_ADDR)) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_CRST: begin
        o_coreRst   = 1'b1;
        o_coreClkEn = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        o_coreClkEn = 1'b1;
        o_coreSi    = w_memRd;
        w_frameDone = w_lastPtr;
        // A stop arriving on the boundary cycle itself still halts here.
        if (w_lastPtr && (r_stopPend || i_stop)) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign o_frameDone = w_frameDone;
  assign o_cfgValid  = r_cfgValid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_cfgValid <= 1'b0;
    end else if (r_state == ST_IDLE && i_load) begin
      r_addr     <= '0;
      r_cfgValid <= 1'b0;
    end else if (w_accept) begin
      r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
      if (r_addr == LAST_ADDR) begin
        r_cfgValid <= 1'b1;
      end
    end
  end

  // Image memory is deliberately left unreset; r_cfgValid qualifies it.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_addr] <= i_wrData;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_CRST) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_RUN) begin
      r_ptr <= w_lastPtr ? '0 : r_ptr + 1'b1;
    end else begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stopPend <= 1'b0;
    end else if (r_state == ST_RUN && w_lastPtr) begin
      r_stopPend <= 1'b0;
    end else if ((r_state == ST_CRST || r_state == ST_RUN) && i_stop) begin
      r_stopPend <= 1'b1;
    end else if (r_state == ST_IDLE || r_state == ST_LOAD) begin
      r_stopPend <= 1'b0;
    end
  end

`ifdef S4GA_SEQ_FRAME_CNT_EN
  logic [15:0] r_frameCnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frameCnt <= '0;
    end else if (w_startAccept) begin
      r_frameCnt <= '0;
    end else if (w_frameDone && (r_frameCnt != 16'hFFFF)) begin
      r_frameCnt <= r_frameCnt + 16'd1;
    end
  end

  assign o_frameCnt = r_frameCnt;
`endif

endmodule

// File: tb/tb_s4ga_seq.sv
// Directed self-checking bench for s4ga_seq at default parameters (image depth 128).
module tb_s4ga_seq;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       start;
  logic       stop;
  logic       wrValid;
  logic [3:0] wrData;
  logic       wrReady;
  logic [3:0] coreSi;
  logic       coreRst;
  logic       coreClkEn;
  logic       busy;
  logic       cfgValid;
  logic       frameDone;
`ifdef S4GA_SEQ_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  logic [3:0] expMem [DEPTH];

  s4ga_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_wrValid   (wrValid),
    .o_wrReady   (wrReady),
    .i_wrData    (wrData),
    .i_start     (start),
    .i_stop      (stop),
    .o_coreSi    (coreSi),
    .o_coreRst   (coreRst),
    .o_coreClkEn (coreClkEn),
    .o_busy      (busy),
    .o_cfgValid  (cfgValid),
    .o_frameDone (frameDone)
`ifdef S4GA_SEQ_FRAME_CNT_EN
    ,
    .o_frameCnt  (frameCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns at the following falling edge with pulses cleared.
  task automatic applyStimulus(input logic ld, input logic st, input logic sp, input logic wv, input logic [3:0] wd);
    load    = ld;
    start   = st;
    stop    = sp;
    wrValid = wv;
    wrData  = wd;
    @(negedge clk);
    load    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    wrValid = 1'b0;
    wrData  = 4'h0;
  endtask

  task automatic loadImage(input bit toggleValid);
    int accepted;
    int steps;
    logic v;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("load_wrready", wrReady, 1);
    checkOutput("load_cfgvalid_cleared", cfgValid, 0);
    checkOutput("load_busy", busy, 1);
    accepted = 0;
    steps    = 0;
    while (accepted < DEPTH && steps < 1000) begin
      v = toggleValid ? ((steps % 2) == 0) : 1'b1;
      if (v && wrReady) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, expMem[accepted]);
        accepted++;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, v, 4'hF);
      end
      steps++;
    end
    checkOutput("load_beats", accepted, DEPTH);
    checkOutput("load_steps", steps, toggleValid ? 2 * DEPTH - 1 : DEPTH);
    checkOutput("load_done_wrready", wrReady, 0);
    checkOutput("load_done_cfgvalid", cfgValid, 1);
    checkOutput("load_done_busy", busy, 0);
  endtask

  task automatic waitCrst(input int stopAt, output int cycles);
    cycles = 0;
    while (coreRst && cycles < 100) begin
      if (cycles == 0) begin
        checkOutput("crst_clken", coreClkEn, 1);
        checkOutput("crst_si", coreSi, 0);
        checkOutput("crst_busy", busy, 1);
      end
      applyStimulus(1'b0, 1'b0, (cycles == stopAt), 1'b0, 4'h0);
      cycles++;
    end
  endtask

  // Called on the first RUN cycle (ptr=0); k tracks ptr across frames.
  task automatic runRun(input int stopK, input int maxK, output int haltK);
    int k;
    k     = 0;
    haltK = -1;
    while (k < maxK) begin
      checkOutput("run_si", coreSi, expMem[k % DEPTH]);
      checkOutput("run_frame_done", frameDone, ((k % DEPTH) == DEPTH - 1));
      if (k == 0) begin
        checkOutput("run_core_rst", coreRst, 0);
        checkOutput("run_clken", coreClkEn, 1);
      end
      if (k == 11) begin
        checkOutput("run_wrready", wrReady, 0);
      end
      applyStimulus((k == 10), (k == 10), (k == stopK), 1'b0, 4'h0);
      if (!busy) begin
        haltK = k;
        break;
      end
      k++;
    end
  endtask

  task automatic checkHalted(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_clken"}, coreClkEn, 0);
    checkOutput({tag, "_si"}, coreSi, 0);
    checkOutput({tag, "_core_rst"}, coreRst, 0);
    checkOutput({tag, "_cfgvalid"}, cfgValid, 1);
  endtask

  initial begin
    int c;
    int h;
    rst     = 1'b1;
    load    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    wrValid = 1'b0;
    wrData  = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wrready", wrReady, 0);
    checkOutput("reset_cfgvalid", cfgValid, 0);
    checkOutput("reset_clken", coreClkEn, 0);
    checkOutput("reset_core_rst", coreRst, 0);
    checkOutput("reset_si", coreSi, 0);
    checkOutput("reset_frame_done", frameDone, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      expMem[i] = 4'((i * 5 + 3) % 16);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("early_start_busy", busy, 0);
    checkOutput("early_start_clken", coreClkEn, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    checkOutput("idle_stop_busy", busy, 0);

    loadImage(1'b1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    waitCrst(-1, c);
    checkOutput("crst_cycles_a", c, 17);
    runRun(DEPTH + 5, 600, h);
    checkOutput("halt_ptr5_k", h, 2 * DEPTH - 1);
    checkHalted("halt_a");
`ifdef S4GA_SEQ_FRAME_CNT_EN
    checkOutput("frame_cnt_two", frameCnt, 2);
`endif

    for (int i = 0; i < DEPTH; i++) begin
      expMem[i] = 4'(i % 16);
    end
    loadImage(1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
`ifdef S4GA_SEQ_FRAME_CNT_EN
    checkOutput("frame_cnt_restart", frameCnt, 0);
`endif
    waitCrst(3, c);
    checkOutput("crst_cycles_b", c, 17);
    runRun(-1, 600, h);
    checkOutput("halt_crst_stop_k", h, DEPTH - 1);
    checkHalted("halt_b");

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    waitCrst(-1, c);
    checkOutput("crst_cycles_c", c, 17);
    runRun(DEPTH - 1, 600, h);
    checkOutput("halt_boundary_k", h, DEPTH - 1);
    checkHalted("halt_c");
`ifdef S4GA_SEQ_FRAME_CNT_EN
    checkOutput("frame_cnt_one", frameCnt, 1);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    waitCrst(-1, c);
    runRun(-1, 40, h);
    checkOutput("run_to_40_no_halt", h, -1);
    checkOutput("run_40_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_cfgvalid", cfgValid, 0);
    checkOutput("async_rst_clken", coreClkEn, 0);
    checkOutput("async_rst_si", coreSi, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("post_rst_start_busy", busy, 0);
    checkOutput("post_rst_start_clken", coreClkEn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/s4ga_seq.md
S4GA_SEQ -- requirements
Module: s4ga_seq

Interface
REQ-001 Parameter N, default 16: number of LUTs in the driven s4ga core.
REQ-002 Parameter K, default 4: LUT inputs per LUT.
REQ-003 Parameter SI_W, default 4: configuration segment width.
REQ-004 Derived constants:
  - IDX_SEGS = ceil(clog2(N)/SI_W); MASK_SEGS = ceil(2^K/SI_W).
  - LUT_SEGS = K*IDX_SEGS + MASK_SEGS; DEPTH = N*LUT_SEGS (128 at defaults).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 load  in  1  pulse; starts configuration load.
REQ-008 wr_valid  in  1  config beat valid.
REQ-009 wr_ready  out  1  config beat accepted when wr_valid&wr_ready.
REQ-010 wr_data  in  SI_W  config segment.
REQ-011 start  in  1  pulse; begin core execution.
REQ-012 stop  in  1  pulse; request halt at next frame boundary.
REQ-013 core_si  out  SI_W  segment stream to core.
REQ-014 core_rst  out  1  core sync reset.
REQ-015 core_clk_en  out  1  core clock-gate enable.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 cfg_valid  out  1  complete config image held.
REQ-018 frame_done  out  1  one-cycle pulse on last segment of a frame.

Function
REQ-019 FSM states: IDLE, LOAD, CRST, RUN; config memory DEPTH x SI_W, asynchronous read.
REQ-020 IDLE: load=1 -> LOAD, addr=0, cfg_valid=0; else start=1 with cfg_valid=1 -> CRST, cnt=0; load has priority over start.
REQ-021 start with cfg_valid=0, or load/start outside IDLE, SHALL be ignored.
REQ-022 LOAD: wr_ready=1; each accepted beat writes mem[addr]=wr_data, addr++; accepted beat at addr=DEPTH-1 -> IDLE, cfg_valid=1 the next cycle.
REQ-023 wr_ready SHALL be 0 outside LOAD; wr_valid gaps SHALL stall LOAD indefinitely.
REQ-024 CRST: core_rst=1, core_clk_en=1, core_si=0 for exactly N+1 cycles, then -> RUN with ptr=0.
REQ-025 RUN: core_rst=0, core_clk_en=1, core_si=mem[ptr]; ptr increments every cycle, wraps DEPTH-1 -> 0.
REQ-026 frame_done=1 in the RUN cycle where ptr=DEPTH-1.
REQ-027 stop in CRST or RUN SHALL set stop_pend; at the next ptr=DEPTH-1 cycle with stop_pend -> IDLE, stop_pend cleared.
REQ-028 stop and frame boundary in the same cycle: the halt takes effect at that boundary.
REQ-029 stop in IDLE or LOAD SHALL be ignored.
REQ-030 IDLE and LOAD: core_clk_en=0, core_rst=0, core_si=0; the core state is frozen by the gate, and restart re-enters CRST.
REQ-031 Sequencing SHALL guarantee the core receives segments in LUT order with no dropped or duplicated cycles while core_clk_en=1.

Reset
REQ-032 rst SHALL asynchronously force:
  - state=IDLE; addr, ptr, cnt, stop_pend = 0.
  - cfg_valid, wr_ready, busy, frame_done, core_clk_en, core_si = 0.
  - core_rst = 0.
REQ-033 Memory contents SHALL NOT be reset; cfg_valid=0 marks them invalid.
REQ-034 rst mid-LOAD or mid-RUN SHALL abandon the operation; load is required again before start.

Configuration
REQ-035 Macro S4GA_SEQ_FRAME_CNT_EN defined:
  - Output port frame_cnt [15:0].
  - Cleared on start acceptance and on rst.
  - +1 on each frame_done; saturates at 0xFFFF.
REQ-036 Macro S4GA_SEQ_FRAME_CNT_EN undefined: frame_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Load at defaults: load pulse, 128 beats with wr_data=addr[3:0] -> wr_ready low after the 128th beat, cfg_valid=1, busy=0.
REQ-038 Start: start pulse after load -> core_rst=1 for exactly 17 cycles, then core_si sequence 0,1,..,F repeating with period 128; frame_done every 128th cycle.
REQ-039 Stop: stop pulse at ptr=5 -> RUN continues to ptr=127, frame_done=1, then IDLE, core_clk_en=0; stop at ptr=127 -> halt on that same cycle.
REQ-040 Backpressure: wr_valid toggled 1,0,1,0 during LOAD -> exactly 128 accepted beats, memory image matches the written data.
REQ-041 Illegal requests and reset:
  - start before load -> no state change.
  - rst at RUN ptr=40 -> immediate IDLE, cfg_valid=0.
  - subsequent start -> ignored.
REQ-042 With S4GA_SEQ_FRAME_CNT_EN: 3 frames -> frame_cnt=3; restart -> 0; forced 0xFFFF plus one frame -> stays 0xFFFF.
